// File: rtl/uart_recv_if.sv
// Serial-in / byte-out bundle for the 8N1 UART receiver.
// Receiver uses the slave side; the line driver uses the master side.
interface uart_recv_if;
    logic       din;
    logic       valid;
    logic [7:0] data;
    logic       frame_err;
    logic       busy;

    modport master (
        output din,
        input  valid,
        input  data,
        input  frame_err,
        input  busy
    );

    modport slave (
        input  din,
        output valid,
        output data,
        output frame_err,
        output busy
    );
endinterface

// File: rtl/uart_recv.sv
// Purpose: 8N1 UART receiver, mid-bit sampling, byte out with one-cycle valid/frame_err strobes.
// Latency: valid 2 + HALF_CYC + 9*BIT_CYC (+0/+2) cycles after the start edge.
// Backpressure: none; each byte is strobed once and data holds until the next good frame.
module uart_recv #(
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic        clk,
    input  logic        rst,
    uart_recv_if.slave  rx
);
    localparam int BIT_CYC  = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam int CNT_W    = $clog2(BIT_CYC);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_CYC - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shreg, shreg_nxt;
    logic [7:0]       data_q, data_nxt;
    logic             valid_q, valid_nxt;
    logic             ferr_q, ferr_nxt;
    logic             sync1, din_s, din_s_d;

    // din is asynchronous; only din_s / din_s_d feed the FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= 1'b1;
            din_s   <= 1'b1;
            din_s_d <= 1'b1;
        end else begin
            sync1   <= rx.din;
            din_s   <= sync1;
            din_s_d <= din_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        data_nxt    = data_q;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (din_s_d && !din_s) begin
                    state_nxt = START;
                    cnt_nxt   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = din_s ? IDLE : DATA;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    shreg_nxt = {din_s, shreg[7:1]};
                    cnt_nxt   = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STOP: begin
                // leave at mid-stop so a back-to-back start edge is not missed
                if (cnt == BIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                    if (din_s) begin
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
                    end else begin
                        ferr_nxt = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx.valid     = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.data      = data_q;
    assign rx.busy      = (state != IDLE);
endmodule
